// File: rtl/pop_uart_dump.sv
// Snapshots a population vector on a trigger rising edge and streams
// it out as 8N1 UART frames, LSB first, pulsing done at the end.
module pop_uart_dump #(
  parameter int POP_BITS     = 7500,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trigger,
  input  logic [POP_BITS-1:0] population,
  output logic                tx,
  output logic                busy,
  output logic                done,
  output logic [9:0]          byte_idx
);

  localparam int NBYTES = (POP_BITS + 7) / 8;
  localparam int SNAP_W = NBYTES * 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [9:0] LAST = 10'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              trig_q, trig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [9:0]        bidx_q, bidx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic              wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    trig_d  = trigger;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    bidx_d  = bidx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    snap_d  = snap_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger && !trig_q) begin
          state_d = S_START;
          snap_d  = SNAP_W'(population);
          bidx_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = snap_q[0];
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = snap_q[bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d = '0;
          if (bidx_q < LAST) begin
            // the current byte always sits in snap_q[7:0]
            state_d = S_START;
            bidx_d  = bidx_q + 10'd1;
            snap_d  = snap_q >> 8;
            tx_d    = 1'b0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      bidx_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      bidx_q  <= bidx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // wide snapshot needs no reset; it is loaded before any use
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign byte_idx = bidx_q;

endmodule

// File: tb/tb_pop_uart_dump.sv
// Bench for pop_uart_dump: three instances, UART frame decoding
// against bytes built directly from the population vector.
module tb_pop_uart_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [3];
  logic        trig [3];
  logic [15:0]   pop_a;
  logic [11:0]   pop_b;
  logic [7499:0] pop_c;
  logic        tx_a, tx_b, tx_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [9:0]  bidx_a, bidx_b, bidx_c;

  pop_uart_dump #(.POP_BITS(16), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .rst_n(rstn[0]), .trigger(trig[0]),
    .population(pop_a), .tx(tx_a), .busy(busy_a),
    .done(done_a), .byte_idx(bidx_a)
  );
  pop_uart_dump #(.POP_BITS(12), .CLKS_PER_BIT(4)) u_b (
    .clk(clk), .rst_n(rstn[1]), .trigger(trig[1]),
    .population(pop_b), .tx(tx_b), .busy(busy_b),
    .done(done_b), .byte_idx(bidx_b)
  );
  pop_uart_dump #(.POP_BITS(7500), .CLKS_PER_BIT(2)) u_c (
    .clk(clk), .rst_n(rstn[2]), .trigger(trig[2]),
    .population(pop_c), .tx(tx_c), .busy(busy_c),
    .done(done_c), .byte_idx(bidx_c)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx_a : (w == 1) ? tx_b : tx_c;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
  endfunction
  function automatic logic [9:0] get_bidx(input int w);
    return (w == 0) ? bidx_a : (w == 1) ? bidx_b : bidx_c;
  endfunction

  // byte k = population bits 8k..8k+7, zero beyond the vector width
  task automatic build_exp(input logic [7503:0] v, input int bits);
    int nb;
    logic [7:0] by;
    nb = (bits + 7) / 8;
    exp_q.delete();
    for (int k = 0; k < nb; k++) begin
      by = 8'h00;
      for (int i = 0; i < 8; i++)
        if (8 * k + i < bits) by[i] = v[8 * k + i];
      exp_q.push_back(by);
    end
  endtask

  // called right after trigger was raised at a falling edge
  task automatic capture(input int w, input int cpb, input string tag);
    int lat, glitch, busy_bad, done_bad, idx_bad;
    logic [9:0] frame;
    logic s, prev;
    lat = 0; glitch = 0; busy_bad = 0; done_bad = 0; idx_bad = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (get_tx(w) == 1'b1 && lat < 64);
    chk({tag, "_latency"}, lat, 1);
    prev = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      frame = '0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < cpb; c++) begin
          s = get_tx(w);
          if (c == cpb / 2) frame[b] = s;
          if (c > 0 && s != prev) glitch++;
          if (!get_busy(w)) busy_bad++;
          if (get_done(w)) done_bad++;
          if (get_bidx(w) != 10'(k)) idx_bad++;
          prev = s;
          @(negedge clk);
        end
      end
      chk($sformatf("%s_frame%0d", tag, k), frame,
          {1'b1, exp_q[k], 1'b0});
    end
    chk({tag, "_done"}, get_done(w), 1);
    chk({tag, "_busy_end"}, get_busy(w), 0);
    chk({tag, "_tx_end"}, get_tx(w), 1);
    chk({tag, "_glitch"}, glitch, 0);
    chk({tag, "_busy_during"}, busy_bad, 0);
    chk({tag, "_done_early"}, done_bad, 0);
    chk({tag, "_byte_idx"}, idx_bad, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, get_done(w), 0);
  endtask

  task automatic quiet(input int w, input int n, input string tag);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      if (!get_tx(w) || get_busy(w) || get_done(w)) act++;
      @(negedge clk);
    end
    chk(tag, act, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0;
      trig[i] = 1'b0;
    end
    pop_a = '0; pop_b = '0; pop_c = '0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("rst_tx%0d", w), get_tx(w), 1);
      chk($sformatf("rst_busy%0d", w), get_busy(w), 0);
      chk($sformatf("rst_done%0d", w), get_done(w), 0);
      chk($sformatf("rst_bidx%0d", w), get_bidx(w), 0);
    end
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    repeat (10) @(negedge clk);

    pop_a = 16'hA53C;
    build_exp(7504'(pop_a), 16);
    trig[0] = 1'b1;
    capture(0, 4, "a53c");
    trig[0] = 1'b0;
    @(negedge clk);

    pop_b = 12'hFFF;
    build_exp(7504'(pop_b), 12);
    trig[1] = 1'b1;
    capture(1, 4, "fff");
    quiet(1, 60, "held_no_redump");
    trig[1] = 1'b0;
    @(negedge clk);
    trig[1] = 1'b1;
    capture(1, 4, "fff_again");
    trig[1] = 1'b0;
    @(negedge clk);

    pop_a = 16'hA53C;
    build_exp(7504'(pop_a), 16);
    trig[0] = 1'b1;
    fork
      capture(0, 4, "snap");
      begin
        repeat (5) @(negedge clk);
        pop_a = '0;
      end
    join
    trig[0] = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      pop_a = 16'($urandom);
      pop_b = 12'($urandom);
      build_exp(7504'(pop_a), 16);
      trig[0] = 1'b1;
      capture(0, 4, $sformatf("rnd_a%0d", r));
      trig[0] = 1'b0;
      build_exp(7504'(pop_b), 12);
      trig[1] = 1'b1;
      capture(1, 4, $sformatf("rnd_b%0d", r));
      trig[1] = 1'b0;
      @(negedge clk);
    end

    pop_a = 16'hA53C;
    trig[0] = 1'b1;
    begin
      int lat;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (tx_a && lat < 64);
      chk("rst_mid_start", tx_a, 0);
    end
    repeat (50) @(negedge clk);
    chk("rst_mid_busy_before", busy_a, 1);
    rstn[0] = 1'b0;
    #1;
    chk("rst_mid_tx", tx_a, 1);
    chk("rst_mid_busy", busy_a, 0);
    trig[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    quiet(0, 60, "rst_mid_quiet");
    build_exp(7504'(pop_a), 16);
    trig[0] = 1'b1;
    capture(0, 4, "after_rst");
    trig[0] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7500; i++) pop_c[i] = 1'($urandom_range(0, 1));
    build_exp(7504'(pop_c), 7500);
    chk("big_nbytes", exp_q.size(), 938);
    trig[2] = 1'b1;
    capture(2, 2, "big");
    trig[2] = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
